wb_reg_file: RTL and testbench
==============================

WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 Parameter SP_INIT, default 32'h0000_0000: reset value of register $29.
REQ-002 Clk  in  1  clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-high; clock Clk.
REQ-004 WB_RegWrite  in  1  primary write enable.
REQ-005 WB_RegWrite2  in  1  secondary write enable (base-register update).
REQ-006 WB_MemtoReg  in  1  primary data select: 1 = memory data, 0 = ALU result.
REQ-007 WB_Jump  in  1  link write: primary data = PC+4.
REQ-008 WB_RegDst  in  2  primary destination select.
REQ-009 WB_MemDataOut, WB_ALUResult, WB_PCAddResult  in  32 each  writeback data sources.
REQ-010 WB_Instruction  in  32  instruction word; register fields decoded from it.
REQ-011 ReadReg1, ReadReg2  in  5 each  read addresses.
REQ-012 ReadData1, ReadData2  out  32 each  read data.
REQ-013 WB_WriteReg  out  5  decoded primary destination (forwarding unit).
REQ-014 WB_WriteData  out  32  selected primary data (forwarding unit).
REQ-015 RetireCount  out  32  count of committed primary writes.

Function
REQ-016 Primary destination SHALL be Instruction[20:16] for RegDst=0, Instruction[15:11] for 1, 5'd31 for 2, and 5'd0 for 3.
REQ-017 Primary data SHALL be PCAddResult if Jump=1; otherwise MemDataOut if MemtoReg=1; otherwise ALUResult.
REQ-018 Secondary write SHALL store ALUResult into register Instruction[25:21].
REQ-019 Writes SHALL commit on the rising edge of Clk; latency from input to stored value is one edge.
REQ-020 Writes to $0 SHALL be discarded; reads of $0 SHALL return 0.
REQ-021 If both ports target the same nonzero register in one cycle, the primary write SHALL win.
REQ-022 Reads SHALL be combinational with write-through bypass: if a read address equals an enabled, nonzero write address in the same cycle, the read returns that write's data. Primary takes precedence over secondary.
REQ-023 WB_WriteReg and WB_WriteData SHALL be combinational decodes, valid every cycle regardless of enables.
REQ-024 RetireCount SHALL increment by 1 on each edge with WB_RegWrite=1 and destination nonzero. It wraps from 32'hFFFF_FFFF to 0.
REQ-025 RegWrite2 alone SHALL NOT affect RetireCount.

Reset
REQ-026 On a Rst=1 edge, all registers SHALL be cleared to 0, except $29, which is set to SP_INIT. RetireCount SHALL also be cleared to 0.
REQ-027 Rst SHALL take priority over any same-edge write.
REQ-028 Bypass SHALL be disabled while Rst=1; reads return the stored value.

Structure
REQ-029 A shared package SHALL hold the RegDst encodings (RT=0, RD=1, RA=2), the register constants REG_ZERO=0, REG_SP=29 and REG_RA=31, and the register-field bit positions.
REQ-030 A single sub-module, wb_dest_mux, SHALL implement REQ-016/017 combinationally. The storage array, bypass logic and counter SHALL remain in wb_reg_file.

Verification
REQ-031 Case 1, reset and link write.
- Stimulus: Rst pulse; then read $29 and $5; then Jump=1, RegDst=2, PCAddResult=32'h0000_0044, RegWrite=1.
- Required: $29 reads SP_INIT and $5 reads 0 after reset. $31 reads 32'h44 after the edge. RetireCount=1.
REQ-032 Case 2, load with bypass.
- Stimulus: MemtoReg=1, RegDst=0, Instruction[20:16]=8, MemDataOut=32'hDEAD_BEEF, RegWrite=1, ReadReg1=8, all in the same cycle.
- Required: ReadData1=32'hDEADBEEF before the edge, and the same value is stored after the edge.
REQ-033 Case 3, $0 write.
- Stimulus: RegDst=1, Instruction[15:11]=0, ALUResult=32'h1234, RegWrite=1.
- Required: $0 still reads 0 and RetireCount is unchanged.
REQ-034 Case 4, dual-port collision.
- Stimulus: RegWrite=RegWrite2=1, both destinations = 9, MemtoReg=1, MemDataOut=32'hAAAA, ALUResult=32'hBBBB.
- Required: $9 = 32'hAAAA. With distinct destinations 9 and 10, $9 = 32'hAAAA and $10 = 32'hBBBB.
REQ-035 Case 5, reset priority.
- Stimulus: Rst=1 and RegWrite=1 to $7 with 32'h55 on the same edge.
- Required: $7 = 0 and RetireCount = 0.
REQ-036 Case 6, counter wrap.
- Stimulus: force RetireCount to 32'hFFFF_FFFF through writes or a backdoor, then perform one valid write.
- Required: RetireCount = 0.

Source files
------------

// File: rtl/wb_reg_file_pkg.sv
// wb_reg_file_pkg: shared writeback encodings, register constants and instruction field positions
package wb_reg_file_pkg;

    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RA = 2'd2
    } regdst_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

endpackage

// File: rtl/wb_dest_mux.sv
// wb_dest_mux: decodes the primary writeback destination and selects its data
module wb_dest_mux
    import wb_reg_file_pkg::*;
(
    input  logic [1:0]  reg_dst,
    input  logic        jump,
    input  logic        mem_to_reg,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_data,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_add_result,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
);

    always_comb begin
        write_reg  = reg_dst == REGDST_RT ? instruction[RT_MSB:RT_LSB] :
                     reg_dst == REGDST_RD ? instruction[RD_MSB:RD_LSB] :
                     reg_dst == REGDST_RA ? REG_RA : REG_ZERO;
        write_data = jump ? pc_add_result : mem_to_reg ? mem_data : alu_result;
    end

endmodule

// File: rtl/wb_reg_file.sv
// wb_reg_file: 32x32 register file with dual writeback ports, write-through reads
// and a retired-write counter
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        WB_RegWrite,
    input  logic        WB_RegWrite2,
    input  logic        WB_MemtoReg,
    input  logic        WB_Jump,
    input  logic [1:0]  WB_RegDst,
    input  logic [31:0] WB_MemDataOut,
    input  logic [31:0] WB_ALUResult,
    input  logic [31:0] WB_PCAddResult,
    input  logic [31:0] WB_Instruction,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [4:0]  WB_WriteReg,
    output logic [31:0] WB_WriteData,
    output logic [31:0] RetireCount
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [4:0]  base_reg;
    logic        wr1_en, wr2_en;

    wb_dest_mux u_dest_mux (
        .reg_dst      (WB_RegDst),
        .jump         (WB_Jump),
        .mem_to_reg   (WB_MemtoReg),
        .instruction  (WB_Instruction),
        .mem_data     (WB_MemDataOut),
        .alu_result   (WB_ALUResult),
        .pc_add_result(WB_PCAddResult),
        .write_reg    (WB_WriteReg),
        .write_data   (WB_WriteData)
    );

    // Reset suppresses both ports, which also disables the bypass path
    assign base_reg = WB_Instruction[RS_MSB:RS_LSB];
    assign wr1_en   = WB_RegWrite && WB_WriteReg != REG_ZERO && !Rst;
    assign wr2_en   = WB_RegWrite2 && base_reg != REG_ZERO && !Rst;

    always_comb begin
        regs_d       = regs_q;
        retire_cnt_d = wr1_en ? retire_cnt_q + 32'd1 : retire_cnt_q;
        if (wr2_en) regs_d[base_reg] = WB_ALUResult;
        if (wr1_en) regs_d[WB_WriteReg] = WB_WriteData;
        if (Rst) begin
            for (int i = 0; i < 32; i++) regs_d[i] = '0;
            regs_d[REG_SP] = SP_INIT;
            retire_cnt_d   = '0;
        end
    end

    always_ff @(posedge Clk) begin
        regs_q       <= regs_d;
        retire_cnt_q <= retire_cnt_d;
    end

    always_comb begin
        ReadData1 = ReadReg1 == REG_ZERO ? '0 :
                    wr1_en && ReadReg1 == WB_WriteReg ? WB_WriteData :
                    wr2_en && ReadReg1 == base_reg ? WB_ALUResult : regs_q[ReadReg1];
        ReadData2 = ReadReg2 == REG_ZERO ? '0 :
                    wr1_en && ReadReg2 == WB_WriteReg ? WB_WriteData :
                    wr2_en && ReadReg2 == base_reg ? WB_ALUResult : regs_q[ReadReg2];
    end

    assign RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed vector table plus hand sequences for reset priority and counter wrap
module tb_wb_reg_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;

    logic        Clk = 1'b0;
    logic        Rst, WB_RegWrite, WB_RegWrite2, WB_MemtoReg, WB_Jump;
    logic [1:0]  WB_RegDst;
    logic [31:0] WB_MemDataOut, WB_ALUResult, WB_PCAddResult, WB_Instruction;
    logic [4:0]  ReadReg1, ReadReg2, WB_WriteReg;
    logic [31:0] ReadData1, ReadData2, WB_WriteData, RetireCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw, rw2, m2r, jmp;
        logic [1:0]  dst;
        logic [31:0] mem, alu, pc, ins;
        logic [4:0]  r1, r2;
        logic [31:0] e1, e2;
        logic [4:0]  ewr;
        logic [31:0] ewd, ecnt;
    } vec_t;

    vec_t vecs [14];

    wb_reg_file #(.SP_INIT(SP)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .WB_RegWrite   (WB_RegWrite),
        .WB_RegWrite2  (WB_RegWrite2),
        .WB_MemtoReg   (WB_MemtoReg),
        .WB_Jump       (WB_Jump),
        .WB_RegDst     (WB_RegDst),
        .WB_MemDataOut (WB_MemDataOut),
        .WB_ALUResult  (WB_ALUResult),
        .WB_PCAddResult(WB_PCAddResult),
        .WB_Instruction(WB_Instruction),
        .ReadReg1      (ReadReg1),
        .ReadReg2      (ReadReg2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WB_WriteReg   (WB_WriteReg),
        .WB_WriteData  (WB_WriteData),
        .RetireCount   (RetireCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        {WB_RegWrite, WB_RegWrite2, WB_MemtoReg, WB_Jump} = 4'b0;
        WB_RegDst = 2'd0;
        {WB_MemDataOut, WB_ALUResult, WB_PCAddResult, WB_Instruction} = '0;
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h44, 32'h0, 5'd31, 5'd29,
                     32'h44, SP, 5'd31, 32'h44, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd0,
                     32'h44, 32'h0, 5'd0, 32'h0, 32'd1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, ins(5'd0, 5'd8, 5'd0), 5'd8, 5'd31,
                     32'hDEAD_BEEF, 32'h44, 5'd8, 32'hDEAD_BEEF, 32'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, ins(5'd0, 5'd8, 5'd0), 5'd8, 5'd31,
                     32'hDEAD_BEEF, 32'h44, 5'd8, 32'hDEAD_BEEF, 32'd2};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 32'h1234, 32'h0, ins(5'd0, 5'd3, 5'd0), 5'd0, 5'd3,
                     32'h0, 32'h0, 5'd0, 32'h1234, 32'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'hAAAA, 32'hBBBB, 32'h0, ins(5'd9, 5'd9, 5'd0), 5'd9, 5'd9,
                     32'hAAAA, 32'hAAAA, 5'd9, 32'hAAAA, 32'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, ins(5'd9, 5'd9, 5'd0), 5'd9, 5'd0,
                     32'hAAAA, 32'h0, 5'd9, 32'h0, 32'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'hAAAA, 32'hBBBB, 32'h0, ins(5'd10, 5'd9, 5'd0), 5'd10, 5'd9,
                     32'hBBBB, 32'hAAAA, 5'd9, 32'hAAAA, 32'd4};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd10,
                     32'hAAAA, 32'hBBBB, 5'd0, 32'h0, 32'd4};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'd77, 32'h0, ins(5'd12, 5'd0, 5'd0), 5'd12, 5'd0,
                     32'd77, 32'h0, 5'd0, 32'd77, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'd99, 32'h0, 32'h0, 5'd0, 5'd12,
                     32'h0, 32'd77, 5'd0, 32'd99, 32'd4};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1, 32'h2, 32'd300, ins(5'd0, 5'd0, 5'd13), 5'd13, 5'd12,
                     32'd300, 32'd77, 5'd13, 32'd300, 32'd5};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'd66, 32'h0, ins(5'd0, 5'd4, 5'd5), 5'd4, 5'd5,
                     32'h0, 32'h0, 5'd0, 32'd66, 32'd5};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd13,
                     32'h44, 32'd300, 5'd0, 32'h0, 32'd5};

        idle();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd5;
        #1;
        check("reset_sp", ReadData1, SP);
        check("reset_r5", ReadData2, 32'h0);
        check("reset_cnt", RetireCount, 32'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            WB_RegWrite    = vecs[i].rw;
            WB_RegWrite2   = vecs[i].rw2;
            WB_MemtoReg    = vecs[i].m2r;
            WB_Jump        = vecs[i].jmp;
            WB_RegDst      = vecs[i].dst;
            WB_MemDataOut  = vecs[i].mem;
            WB_ALUResult   = vecs[i].alu;
            WB_PCAddResult = vecs[i].pc;
            WB_Instruction = vecs[i].ins;
            ReadReg1       = vecs[i].r1;
            ReadReg2       = vecs[i].r2;
            #1;
            check($sformatf("v%0d_rd1", i), ReadData1, vecs[i].e1);
            check($sformatf("v%0d_rd2", i), ReadData2, vecs[i].e2);
            check($sformatf("v%0d_wreg", i), {27'd0, WB_WriteReg}, {27'd0, vecs[i].ewr});
            check($sformatf("v%0d_wdata", i), WB_WriteData, vecs[i].ewd);
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_cnt", i), RetireCount, vecs[i].ecnt);
        end

        // Reset beats a same-edge write, and reads see stored data instead of the bypass
        @(negedge Clk);
        idle();
        Rst = 1'b1;
        WB_RegWrite = 1'b1;
        WB_Instruction = ins(5'd0, 5'd7, 5'd0);
        WB_ALUResult = 32'h55;
        ReadReg1 = 5'd7;
        ReadReg2 = 5'd9;
        #1;
        check("rst_nobypass_r7", ReadData1, 32'h0);
        check("rst_stored_r9", ReadData2, 32'hAAAA);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        idle();
        ReadReg1 = 5'd7;
        ReadReg2 = 5'd29;
        #1;
        check("rst_pri_r7", ReadData1, 32'h0);
        check("rst_pri_sp", ReadData2, SP);
        check("rst_pri_cnt", RetireCount, 32'h0);
        ReadReg1 = 5'd9;
        ReadReg2 = 5'd31;
        #1;
        check("rst_clr_r9", ReadData1, 32'h0);
        check("rst_clr_r31", ReadData2, 32'h0);

        // Preload the counter to all-ones through its next-state value, then wrap it
        @(negedge Clk);
        force dut.retire_cnt_d = 32'hFFFF_FFFF;
        @(posedge Clk);
        #1;
        check("wrap_preload", RetireCount, 32'hFFFF_FFFF);
        @(negedge Clk);
        release dut.retire_cnt_d;
        WB_RegWrite = 1'b1;
        WB_RegDst = 2'd1;
        WB_Instruction = ins(5'd0, 5'd0, 5'd6);
        WB_ALUResult = 32'h66;
        @(posedge Clk);
        #1;
        check("wrap_cnt", RetireCount, 32'h0);
        idle();
        ReadReg1 = 5'd6;
        #1;
        check("wrap_r6", ReadData1, 32'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
